// File: rtl/arith_pkg.sv
// arith_pkg: shared arithmetic-unit types, nibble width and nibble-count helper
package arith_pkg;
    localparam int NIB_W = 4;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
    function automatic int nib_count(input int width);
        return width / NIB_W;
    endfunction
endpackage

// File: rtl/bls4.sv
// bls4: combinational 4-bit borrow-lookahead subtractor slice
//   x, y : minuend / subtrahend nibble
//   bi   : borrow-in
//   df   : x - y - bi (mod 16)
//   bo   : borrow-out
module bls4 (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       bi,
    output logic [3:0] df,
    output logic       bo
);
    logic [3:0] g, p;
    logic [4:0] br;
    // a bit borrows when x=0,y=1; it passes an incoming borrow when x==y
    assign g = ~x & y;
    assign p = ~(x ^ y);
    assign br[0] = bi;
    assign br[1] = g[0] | (p[0] & bi);
    assign br[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bi);
    assign br[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & bi);
    assign br[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                 | (p[3] & p[2] & p[1] & p[0] & bi);
    assign df = x ^ y ^ br[3:0];
    assign bo = br[4];
endmodule

// File: rtl/nibble_serial_sub.sv
// nibble_serial_sub: multi-cycle unsigned subtractor, one nibble per clock, LSB first
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid/in_ready   : operand handshake (a, b, bin sampled at accept)
//   out_valid/out_ready : result handshake (d, bout held until taken)
//   d, bout             : (a - b - bin) mod 2^WIDTH, borrow-out
//   ovf                 : signed overflow, present only when SUB_OVF_EN is defined
module nibble_serial_sub
    import arith_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             bout
`ifdef SUB_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int NIB   = nib_count(WIDTH);
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               borrow_q, borrow_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [WIDTH-1:0]   d_q, d_d;
    logic               bout_q, bout_d;
    logic [NIB_W-1:0]   df;
    logic               bo;
    logic               last;

    bls4 u_bls4 (
        .x (a_q[idx_q*NIB_W +: NIB_W]),
        .y (b_q[idx_q*NIB_W +: NIB_W]),
        .bi(borrow_q),
        .df(df),
        .bo(bo)
    );

    assign last = idx_q == IDX_W'(NIB - 1);

`ifdef SUB_OVF_EN
    logic ovf_q, ovf_d;
    assign ovf = ovf_q;
`endif

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        borrow_d = borrow_q;
        a_d      = a_q;
        b_d      = b_q;
        work_d   = work_q;
        d_d      = d_q;
        bout_d   = bout_q;
`ifdef SUB_OVF_EN
        ovf_d    = ovf_q;
`endif
        if (state_q == IDLE) begin
            if (in_valid) begin
                a_d      = a;
                b_d      = b;
                borrow_d = bin;
                idx_d    = '0;
                state_d  = RUN;
            end
        end else if (state_q == RUN) begin
            work_d[idx_q*NIB_W +: NIB_W] = df;
            borrow_d = bo;
            idx_d    = idx_q + 1'b1;
            // results are published only once the top nibble is done
            if (last) begin
                d_d     = work_d;
                bout_d  = bo;
`ifdef SUB_OVF_EN
                ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (work_d[WIDTH-1] != a_q[WIDTH-1]);
`endif
                idx_d   = '0;
                state_d = DONE;
            end
        end else if (out_ready) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            borrow_q <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            work_q   <= '0;
            d_q      <= '0;
            bout_q   <= 1'b0;
`ifdef SUB_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            borrow_q <= borrow_d;
            a_q      <= a_d;
            b_q      <= b_d;
            work_q   <= work_d;
            d_q      <= d_d;
            bout_q   <= bout_d;
`ifdef SUB_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign d         = d_q;
    assign bout      = bout_q;
endmodule

// File: tb/tb_nibble_serial_sub.sv
// tb_nibble_serial_sub: table-driven directed bench for nibble_serial_sub (WIDTH=16)
module tb_nibble_serial_sub;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        bin = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] d;
    logic        bout;
`ifdef SUB_OVF_EN
    logic        ovf;
`endif
    int          total = 0;
    int          passed = 0;

    nibble_serial_sub #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
        .d(d), .bout(bout)
`ifdef SUB_OVF_EN
        , .ovf(ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        bin;
        logic [15:0] d;
        logic        bout;
    } vec_t;
    vec_t vecs [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h want %0h", nm, act, exp);
        else passed++;
    endtask

    task automatic run_op(input logic [15:0] va, input logic [15:0] vb, input logic vbin,
                          input logic [15:0] ed, input logic eb);
        int lat;
        @(negedge clk);
        in_valid = 1'b1; a = va; b = vb; bin = vbin;
        chk("in_ready_idle", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0; a = ~va; b = ~vb; bin = ~vbin;
        chk("in_ready_busy", in_ready, 0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", lat, 4);
        chk("d", d, ed);
        chk("bout", bout, eb);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("out_valid_drop", out_valid, 0);
        chk("in_ready_back", in_ready, 1);
    endtask

    initial begin
        logic [15:0] held_d;
        logic        held_b;
        int          lat;
        int          seen;
        vecs[0] = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0};
        vecs[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1};
        vecs[2] = '{16'h5555, 16'h5555, 1'b1, 16'hFFFF, 1'b1};
        vecs[3] = '{16'h5555, 16'h5555, 1'b0, 16'h0000, 1'b0};
        vecs[4] = '{16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b1};
        vecs[5] = '{16'hFFFF, 16'h0000, 1'b1, 16'hFFFE, 1'b0};
        vecs[6] = '{16'hA5C3, 16'h1234, 1'b0, 16'h938F, 1'b0};
        vecs[7] = '{16'h1000, 16'h0001, 1'b1, 16'h0FFE, 1'b0};

        #12;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_d", d, 0);
        chk("rst_bout", bout, 0);
`ifdef SUB_OVF_EN
        chk("rst_ovf", ovf, 0);
`endif
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++)
            run_op(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].d, vecs[i].bout);

`ifdef SUB_OVF_EN
        run_op(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0);
        chk("ovf_set", ovf, 1);
        run_op(16'h7FFF, 16'h0001, 1'b0, 16'h7FFE, 1'b0);
        chk("ovf_clear", ovf, 0);
`endif

        // backpressure: hold the result in DONE while inputs wiggle
        @(negedge clk);
        in_valid = 1'b1; a = 16'h0100; b = 16'h0001; bin = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("bp_latency", lat, 4);
        chk("bp_d", d, 16'h00FF);
        held_d = d;
        held_b = bout;
        for (int k = 0; k < 5; k++) begin
            in_valid = k[0]; a = 16'h1111 * k[15:0];
            @(posedge clk); #1;
            chk("bp_out_valid", out_valid, 1);
            chk("bp_d_hold", d, held_d);
            chk("bp_bout_hold", bout, held_b);
            chk("bp_in_ready", in_ready, 0);
        end
        in_valid = 1'b1; a = 16'h0003; b = 16'h0005; bin = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_release_ov", out_valid, 0);
        chk("bp_release_ir", in_ready, 1);
        chk("bp_release_d", d, 16'h00FF);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_next_accept", in_ready, 0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("bp_next_latency", lat, 4);
        chk("bp_next_d", d, 16'hFFFE);
        chk("bp_next_bout", bout, 1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // reset while RUN with idx=2
        @(negedge clk);
        in_valid = 1'b1; a = 16'h4321; b = 16'h1234; bin = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_d", d, 0);
        chk("mid_rst_bout", bout, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("mid_rst_no_pulse", seen, 0);
        chk("mid_rst_idle", in_ready, 1);
        run_op(16'h4321, 16'h1234, 1'b0, 16'h30ED, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end
endmodule
